voxel_ram_arbiter: RTL
======================

// Module: voxel_ram_arbiter
// PURPOSE
//  Shares one fixed-latency voxel block RAM between NUM_REQ voxel traversal units.
//  Each VTU presents a level-held read request (addr + read_enable) and expects a one-cycle valid pulse with the block.
//  Round-robin grant, one RAM issue per cycle, tag pipeline routes each response back to its requester.
//  Sits between the VTU array and the world voxel RAM.
// PARAMETERS
//  NUM_REQ      4  number of requesters (>=2)
//  RAM_LATENCY  2  cycles from mem_read_enable high (cycle c) to mem_out valid (cycle c+RAM_LATENCY), >=1
// PORTS
//  clk_in           in   1                    clock
//  rst_in           in   1                    asynchronous, active-high reset
//  req_addr         in   NUM_REQ x BlockPos   per-requester voxel address, stable while requesting
//  req_read_enable  in   NUM_REQ              per-requester request level
//  req_out          out  BlockType            response block, shared bus
//  req_valid        out  NUM_REQ              one-hot, req_out belongs to the set bit
//  mem_addr         out  BlockPos             RAM address, registered
//  mem_read_enable  out  1                    RAM read strobe, registered
//  mem_out          in   BlockType            RAM data, fixed latency, no valid
// BEHAVIOUR
//  Reset (async):
//  - mem_addr=0, mem_read_enable=0, req_out=BLOCK_AIR, req_valid=0.
//  - pending=0, rr_ptr=0, tag pipe all invalid.
//  Eligibility:
//  - elig[i] = req_read_enable[i] & !pending[i].
//  - At most one outstanding request per requester.
//  Grant:
//  - Combinational; first elig index searching from rr_ptr upward, mod NUM_REQ.
//  - On grant g at edge: mem_addr<=req_addr[g], mem_read_enable<=1, pending[g]<=1, rr_ptr<=(g+1)%NUM_REQ.
//  - No eligible requester: mem_read_enable<=0, rr_ptr unchanged, mem_addr holds.
//  Tag pipe:
//  - RAM_LATENCY-deep shift register of {valid, idx}, loaded with {mem_read_enable, grant idx} alongside mem_addr.
//  - Its tail aligns with mem_out.
//  Response:
//  - Tail valid with idx k, at edge: req_out<=mem_out; req_valid<=onehot(k) & req_read_enable; else req_valid<=0.
//  - req_out holds its value when no response.
//  - pending[k] clears at the edge after req_valid[k] is high, not before.
//  - Requester k is eligible again no earlier than the cycle after its valid pulse, so the requester's next address is seen.
//  Latency and throughput:
//  - Request level seen in cycle 0 gives mem_read_enable in cycle 1 and req_valid in cycle RAM_LATENCY+2 (uncontended).
//  - Throughput is 1 issue/cycle aggregate.
//  - Per requester, 1 issue per RAM_LATENCY+3 cycles.
//  Boundary conditions:
//  - Requester drops read_enable while pending: response still consumes its slot.
//    The valid pulse is squashed if read_enable is low at delivery; pending clears normally.
//  - Requester raises read_enable in the same cycle another response is delivered: normal arbitration, no interaction.
//  - All requesters active: strict rotation 0,1,..,N-1,0; no requester waits more than NUM_REQ-1 grant cycles once eligible.
//  - rr_ptr wraps from NUM_REQ-1 to 0.
//  - Reset mid-operation: in-flight RAM reads are discarded; no valid pulse follows reset.
//  - Addresses are passed through unmodified; bounds are not checked (RAM's job).
// TESTING
//  1 Reset: assert rst_in mid-burst, async (no clock edge) -> req_valid=0, mem_read_enable=0 immediately; no late pulses.
//  2 Single requester: req 1 addr (3,4,5), RAM model returns BLOCK_STONE, LAT=2
//    -> mem_read_enable cycle 1, req_valid=4'b0010 + STONE in cycle 4.
//  3 All 4 held high, distinct addrs -> grant order 0,1,2,3 on consecutive cycles.
//    Each valid exactly once per round; no re-grant before its own valid+1.
//  4 Requester 2 drops read_enable 1 cycle after grant -> no req_valid[2].
//    Pending clears; re-raise later gets fresh grant.
//  5 Fairness: req 0 always high, req 3 raises at cycle 10 -> req 3 granted within 3 grant cycles.
//    rr_ptr wraps 3->0 correctly.
//  6 Randomized 4 VTU models with scoreboard -> every valid carries mem data for that requester's address at grant.

Source files
------------

// File: rtl/voxel_ram_arbiter.sv
// voxel_ram_arbiter
//
// Lets NUM_REQ voxel traversal units (VTUs) share one fixed-latency voxel block RAM.
// Each VTU holds a read request high (address plus read enable) until it gets its reply.
// One read is issued to the RAM per cycle, and requesters take turns in round-robin order.
// A tag pipeline records which requester each read belongs to, so the response is routed
// back to that requester as a one-cycle valid pulse.
//
// Ports
//   clk_in           clock
//   rst_in           asynchronous, active-high reset
//   req_addr         per-requester voxel address (held stable while requesting)
//   req_read_enable  per-requester request level
//   req_out          shared response block bus
//   req_valid        one-hot; req_out belongs to the set bit
//   mem_addr         registered RAM address
//   mem_read_enable  registered RAM read strobe
//   mem_out          RAM read data, valid RAM_LATENCY cycles after mem_read_enable

module voxel_ram_arbiter #(
  parameter int unsigned          NUM_REQ     = 4,
  parameter int unsigned          RAM_LATENCY = 2,
  parameter int unsigned          AddrWidth   = 15,
  parameter int unsigned          BlockWidth  = 8,
  parameter logic [BlockWidth-1:0] BlockAir   = '0
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_REQ-1:0][AddrWidth-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]                 req_read_enable,
  output logic [BlockWidth-1:0]              req_out,
  output logic [NUM_REQ-1:0]                 req_valid,
  output logic [AddrWidth-1:0]               mem_addr,
  output logic                               mem_read_enable,
  input  logic [BlockWidth-1:0]              mem_out
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned Tail = RAM_LATENCY - 1;

  // Arbitration state
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;

  // RAM issue registers; mem_idx_q travels with mem_addr_q into the tag pipe
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_re_q, mem_re_d;
  logic [IdxW-1:0]      mem_idx_q, mem_idx_d;

  // Tag pipe: stage 0 follows the issue registers, so the tail lines up with mem_out
  logic [RAM_LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [RAM_LATENCY-1:0][IdxW-1:0] tag_idx_q, tag_idx_d;

  // Response registers. resp_vld_q marks a delivered slot even when the pulse was squashed.
  logic [BlockWidth-1:0] req_out_q, req_out_d;
  logic [NUM_REQ-1:0]    req_valid_q, req_valid_d;
  logic                  resp_vld_q, resp_vld_d;
  logic [IdxW-1:0]       resp_idx_q, resp_idx_d;

  // Grant search
  logic [NUM_REQ-1:0] elig;
  logic               grant_vld;
  logic [IdxW-1:0]    grant_idx;
  logic [IdxW:0]      cand_wide;
  logic [IdxW-1:0]    cand;
  logic [NUM_REQ-1:0] tail_onehot;

  always_comb begin
    elig      = req_read_enable & ~pending_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_wide = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand_wide = {1'b0, rr_ptr_q} + (IdxW+1)'(off);
      if (cand_wide >= (IdxW+1)'(NUM_REQ)) begin
        cand_wide = cand_wide - (IdxW+1)'(NUM_REQ);
      end
      cand = cand_wide[IdxW-1:0];
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Issue and pointer update
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_idx_d  = mem_idx_q;
    mem_re_d   = grant_vld;
    rr_ptr_d   = rr_ptr_q;
    if (grant_vld) begin
      mem_addr_d = req_addr[grant_idx];
      mem_idx_d  = grant_idx;
      rr_ptr_d   = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
    end
  end

  // Tag pipe shift
  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = mem_re_q;
    tag_idx_d[0] = mem_idx_q;
    for (int unsigned s = 1; s < RAM_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // Response capture. The pulse is masked by the live request level, so a requester that
  // dropped its request still consumes the slot but sees no pulse.
  always_comb begin
    tail_onehot                 = '0;
    tail_onehot[tag_idx_q[Tail]] = 1'b1;
    req_out_d                   = req_out_q;
    req_valid_d                 = '0;
    resp_vld_d                  = tag_vld_q[Tail];
    resp_idx_d                  = tag_idx_q[Tail];
    if (tag_vld_q[Tail]) begin
      req_out_d   = mem_out;
      req_valid_d = tail_onehot & req_read_enable;
    end
  end

  // Pending clears on the edge after the delivery cycle, so the requester's next address
  // is the one sampled on its following grant.
  always_comb begin
    pending_d = pending_q;
    if (resp_vld_q) begin
      pending_d[resp_idx_q] = 1'b0;
    end
    if (grant_vld) begin
      pending_d[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_idx_q   <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      req_out_q   <= BlockAir;
      req_valid_q <= '0;
      resp_vld_q  <= 1'b0;
      resp_idx_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_idx_q   <= mem_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      req_out_q   <= req_out_d;
      req_valid_q <= req_valid_d;
      resp_vld_q  <= resp_vld_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

  assign mem_addr        = mem_addr_q;
  assign mem_read_enable = mem_re_q;
  assign req_out         = req_out_q;
  assign req_valid       = req_valid_q;

endmodule
